// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO drain path: FSM state encoding,
// default word width and the counter-width helper.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        START   = 3'd2,
        DATA    = 3'd3,
        PARITY  = 3'd4,
        STOP    = 3'd5
    } drain_state_t;

    // Bits needed to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and emits a one-cycle tick on the
// last count; clr forces the count back to zero and suppresses the tick.
module uart_baud_tick
    import fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX) && !clr;

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from the FIFO read port and sends each as a UART frame, LSB
// first. Define FIFO_UART_PARITY_EN to insert an even-parity bit after data.
module fifo_uart_drain
    import fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic [7:0]            frames_sent
);

    localparam int BIT_W = cnt_width(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    drain_state_t          state_q, state_d;
    logic                  tx_q, tx_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [7:0]            frames_q, frames_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
`ifdef FIFO_UART_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic baud_clr;
    logic baud_tick;

    // Pop is decided combinationally in IDLE so the head word arrives during
    // CAPTURE; rst_n gates it so no pop escapes while reset is held.
    assign fifo_pop = rst_n && (state_q == IDLE) && ena && !fifo_empty;
    assign busy     = fifo_pop || (state_q != IDLE);
    assign baud_clr = (state_q == IDLE) || (state_q == CAPTURE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (baud_clr),
        .tick (baud_tick)
    );

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        bit_d    = bit_q;
        frames_d = frames_q;
        shift_d  = shift_q;
`ifdef FIFO_UART_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_pop) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                shift_d = fifo_rd_data;
`ifdef FIFO_UART_PARITY_EN
                par_d   = ^fifo_rd_data;
`endif
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
`ifdef FIFO_UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
`ifdef FIFO_UART_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    state_d  = IDLE;
                    frames_d = frames_q + 8'd1;
                    tx_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            bit_q    <= '0;
            frames_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            bit_q    <= bit_d;
            frames_q <= frames_d;
        end
    end

    // Payload registers carry no reset; CAPTURE always reloads them.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef FIFO_UART_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign tx          = tx_q;
    assign frames_sent = frames_q;

endmodule
